// File: rtl/armleocpu_mem_1wnr_pkg.sv
// armleocpu_mem_1wnr_pkg
// Shared constants and helpers for the single-write, multi-read memory.
// Optional feature macro: ARMLEOCPU_MEM_1WNR_BYPASS_EN (see armleocpu_mem_1wnr.sv).
package armleocpu_mem_1wnr_pkg;

  // Upper bound on the number of independent read ports.
  localparam int MAX_READ_PORTS = 8;

  // Low bit of lane `lane` inside a packed word split into `granulity`-bit lanes.
  function automatic int lane_lo(input int lane, input int granulity);
    return lane * granulity;
  endfunction

endpackage

// File: rtl/armleocpu_mem_1wnr_if.sv
// armleocpu_mem_1wnr_if
// Bus bundle between a requester (master) and the 1WnR memory (slave).
//   write/waddress/writedata/writeenable : single write port, lane enables
//   read/raddress                       : per-port read strobes, packed addresses
//   readdata/readvalid                  : per-port held data, one-cycle valid pulse
// Optional feature macro: ARMLEOCPU_MEM_1WNR_BYPASS_EN (affects the memory only).
interface armleocpu_mem_1wnr_if #(
  parameter  int ELEMENTS_W = 3,
  parameter  int WIDTH      = 16,
  parameter  int GRANULITY  = 8,
  parameter  int READ_PORTS = 2,
  localparam int ENABLES    = WIDTH / GRANULITY
) ();

  logic                             write;
  logic [ELEMENTS_W-1:0]            waddress;
  logic [WIDTH-1:0]                 writedata;
  logic [ENABLES-1:0]               writeenable;
  logic [READ_PORTS-1:0]            read;
  logic [READ_PORTS*ELEMENTS_W-1:0] raddress;
  logic [READ_PORTS*WIDTH-1:0]      readdata;
  logic [READ_PORTS-1:0]            readvalid;

  modport master (
    output write, waddress, writedata, writeenable, read, raddress,
    input  readdata, readvalid
  );

  modport slave (
    input  write, waddress, writedata, writeenable, read, raddress,
    output readdata, readvalid
  );

endinterface

// File: rtl/armleocpu_mem_1wnr_rdport.sv
// armleocpu_mem_1wnr_rdport
// One read port of the 1WnR memory: array read, optional write bypass merge,
// hold register and readvalid flop.
//   clk, rst            : clock, asynchronous active-high reset
//   mem                 : the shared array (owned by the top)
//   read, raddress      : this port's strobe and address
//   write..writeenable  : write-port view, only used for the bypass merge
//   readdata, readvalid : held word and one-cycle fresh-data pulse
// Optional feature macro: ARMLEOCPU_MEM_1WNR_BYPASS_EN selects write-first
// per lane on a same-address collision; otherwise the port is read-first.
module armleocpu_mem_1wnr_rdport
  import armleocpu_mem_1wnr_pkg::*;
#(
  parameter  int ELEMENTS_W = 3,
  parameter  int WIDTH      = 16,
  parameter  int GRANULITY  = 8,
  localparam int ENABLES    = WIDTH / GRANULITY,
  localparam int DEPTH      = 2 ** ELEMENTS_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      mem [DEPTH],
  input  logic                  read,
  input  logic [ELEMENTS_W-1:0] raddress,
  input  logic                  write,
  input  logic [ELEMENTS_W-1:0] waddress,
  input  logic [WIDTH-1:0]      writedata,
  input  logic [ENABLES-1:0]    writeenable,
  output logic [WIDTH-1:0]      readdata,
  output logic                  readvalid
);

  logic [WIDTH-1:0] word_next;
  logic [WIDTH-1:0] readdata_reg;
  logic             readvalid_reg;

`ifdef ARMLEOCPU_MEM_1WNR_BYPASS_EN
  // Enabled lanes of a colliding write overwrite the stale array word.
  always_comb begin
    word_next = mem[raddress];
    if (write && (waddress == raddress)) begin
      for (int m = 0; m < ENABLES; m++) begin
        if (writeenable[m])
          word_next[lane_lo(m, GRANULITY) +: GRANULITY] =
            writedata[lane_lo(m, GRANULITY) +: GRANULITY];
      end
    end
  end
`else
  assign word_next = mem[raddress];
  // Write-port view is only needed by the bypass merge.
  wire unused_bypass_inputs = ^{write, waddress, writedata, writeenable};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readdata_reg  <= '0;
      readvalid_reg <= 1'b0;
    end else begin
      readvalid_reg <= read;
      if (read)
        readdata_reg <= word_next;
    end
  end

  assign readdata  = readdata_reg;
  assign readvalid = readvalid_reg;

endmodule

// File: rtl/armleocpu_mem_1wnr.sv
// armleocpu_mem_1wnr
// Single-write, multi-read synchronous memory with lane write enables and a
// per-port read hold register. The array itself is never reset.
//   clk : clock, all state updates on the rising edge
//   rst : asynchronous active-high reset (clears read outputs, gates writes)
//   bus : armleocpu_mem_1wnr_if.slave (write port, READ_PORTS read ports)
// Optional feature macro: ARMLEOCPU_MEM_1WNR_BYPASS_EN -- same-cycle
// write-to-read bypass (write-first per enabled lane). Default is read-first.
module armleocpu_mem_1wnr
  import armleocpu_mem_1wnr_pkg::*;
#(
  parameter  int ELEMENTS_W = 3,
  parameter  int WIDTH      = 16,
  parameter  int GRANULITY  = 8,
  parameter  int READ_PORTS = 2,
  localparam int ENABLES    = WIDTH / GRANULITY,
  localparam int DEPTH      = 2 ** ELEMENTS_W
) (
  input logic                clk,
  input logic                rst,
  armleocpu_mem_1wnr_if.slave bus
);

  if (WIDTH % GRANULITY != 0) begin : g_bad_granulity
    $error("armleocpu_mem_1wnr: WIDTH must be a multiple of GRANULITY");
  end
  if (READ_PORTS < 1 || READ_PORTS > MAX_READ_PORTS) begin : g_bad_ports
    $error("armleocpu_mem_1wnr: READ_PORTS out of range");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic             write_gate;

  // A write presented while rst is high is dropped.
  assign write_gate = bus.write && !rst;

  always_ff @(posedge clk) begin
    if (write_gate) begin
      for (int m = 0; m < ENABLES; m++) begin
        if (bus.writeenable[m])
          mem[bus.waddress][lane_lo(m, GRANULITY) +: GRANULITY] <=
            bus.writedata[lane_lo(m, GRANULITY) +: GRANULITY];
      end
    end
  end

  for (genvar gi = 0; gi < READ_PORTS; gi++) begin : g_rdport
    armleocpu_mem_1wnr_rdport #(
      .ELEMENTS_W (ELEMENTS_W),
      .WIDTH      (WIDTH),
      .GRANULITY  (GRANULITY)
    ) u_rdport (
      .clk         (clk),
      .rst         (rst),
      .mem         (mem),
      .read        (bus.read[gi]),
      .raddress    (bus.raddress[gi*ELEMENTS_W +: ELEMENTS_W]),
      .write       (bus.write),
      .waddress    (bus.waddress),
      .writedata   (bus.writedata),
      .writeenable (bus.writeenable),
      .readdata    (bus.readdata[gi*WIDTH +: WIDTH]),
      .readvalid   (bus.readvalid[gi])
    );
  end

endmodule
